// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory request/response channel plus the
// decode-side IF/ID outputs and the control inputs coming back from decode/execute.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        StallD;
  logic        FlushD;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    input  StallD, FlushD, PCSrcE, PCTargetE,
    output InstrD, PCD, PCPlus4D, ValidD
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    output StallD, FlushD, PCSrcE, PCTargetE,
    input  InstrD, PCD, PCPlus4D, ValidD
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request outstanding to a
// variable-latency memory, and feeds decode through a skid buffer and IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master f
);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  state_t      state;
  logic [31:0] pc_p0;
  logic [31:0] req_pc_p0;
  logic        skid_vld_p0;
  logic [31:0] skid_instr_p0;
  logic [31:0] skid_pc_p0;
  logic [31:0] instr_p1;
  logic [31:0] pc_p1;
  logic [31:0] pc4_p1;
  logic        vld_p1;

  logic if_free;
  logic accept;
  logic rsp_live;

  // IF/ID can take something when empty or when decode consumes it this cycle.
  assign if_free     = !vld_p1 || !f.StallD;
  assign f.imem_req  = (state == IDLE) && !skid_vld_p0 && if_free && !f.PCSrcE && !rst;
  assign f.imem_addr = pc_p0;
  assign accept      = f.imem_req && f.imem_ready;
  assign rsp_live    = (state == WAIT) && f.imem_rvalid;

  assign f.InstrD   = instr_p1;
  assign f.PCD      = pc_p1;
  assign f.PCPlus4D = pc4_p1;
  assign f.ValidD   = vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc_p0       <= RESET_PC;
      skid_vld_p0 <= 1'b0;
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      pc_p1       <= '0;
      pc4_p1      <= '0;
    end else if (f.PCSrcE) begin
      // Redirect: everything younger than the branch is dead, including an
      // in-flight response, which is dropped when it eventually returns.
      pc_p0       <= f.PCTargetE;
      vld_p1      <= 1'b0;
      skid_vld_p0 <= 1'b0;
      case (state)
        WAIT:    state <= f.imem_rvalid ? IDLE : DROP;
        DROP:    if (f.imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end else begin
      // ---- fetch stage (p0): request issue and response return ----
      case (state)
        IDLE: if (accept) begin
          req_pc_p0 <= pc_p0;
          pc_p0     <= pc_inc(pc_p0);
          state     <= WAIT;
        end
        WAIT, DROP: if (f.imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase

      // ---- IF/ID register (p1) ----
      // A flush kills only the current entry; a response landing the same
      // cycle is parked in the skid so the sequential stream is not lost.
      if (f.FlushD) begin
        vld_p1 <= 1'b0;
        if (rsp_live) begin
          skid_vld_p0   <= 1'b1;
          skid_instr_p0 <= f.imem_rdata;
          skid_pc_p0    <= req_pc_p0;
        end
      end else if (if_free) begin
        if (skid_vld_p0) begin
          vld_p1      <= 1'b1;
          instr_p1    <= skid_instr_p0;
          pc_p1       <= skid_pc_p0;
          pc4_p1      <= pc_inc(skid_pc_p0);
          skid_vld_p0 <= 1'b0;
        end else if (rsp_live) begin
          vld_p1   <= 1'b1;
          instr_p1 <= f.imem_rdata;
          pc_p1    <= req_pc_p0;
          pc4_p1   <= pc_inc(req_pc_p0);
        end else begin
          vld_p1 <= 1'b0;
        end
      end else if (rsp_live) begin
        skid_vld_p0   <= 1'b1;
        skid_instr_p0 <= f.imem_rdata;
        skid_pc_p0    <= req_pc_p0;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed reset/cadence/wrap checks, then randomized
// stall/flush/redirect/latency traffic against a program-order reference model.
module tb_fetch_stage;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if f();
  fetch_stage_if w();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .f(f));
  fetch_stage #(.RESET_PC(WRAP_PC))       dut_wrap (.clk(clk), .rst(rst), .f(w));

  int checks = 0;
  int errors = 0;

  bit          dir = 1'b0;
  bit          rnd = 1'b0;
  int          cyc = 0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [31:0] baddr = '0;

  // Reference model state
  logic [31:0] exp_pc = '0;
  logic [31:0] nf = '0;
  bit          outst = 1'b0;
  bit          rst_last = 1'b0;
  bit          h_hold = 1'b0;
  bit          h_kill = 1'b0;
  logic [31:0] h_instr, h_pcd, h_pc4;
  int          delivered = 0;
  int          idle = 0;
  int          max_idle = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, req, $time);
    end
  endtask

  task automatic dir_check();
    bit ev;
    ev = (cyc >= 3) && (cyc % 2 == 1);
    chk("valid_cadence", 32'(f.ValidD), 32'(ev));
    chk("req_cadence", 32'(f.imem_req), 32'(cyc % 2 == 1));
    if (ev) begin
      chk("pcd_seq", f.PCD, 32'((cyc - 3) * 2));
      chk("pcp4_seq", f.PCPlus4D, 32'((cyc - 3) * 2 + 4));
      chk("instr_seq", f.InstrD, word(32'((cyc - 3) * 2)));
    end
    if (cyc == 1) chk("wrap_addr0", w.imem_addr, WRAP_PC);
    if (cyc == 3) begin
      chk("wrap_addr1", w.imem_addr, 32'h0);
      chk("wrap_pcd", w.PCD, WRAP_PC);
      chk("wrap_pcp4", w.PCPlus4D, 32'h0);
    end
    if (cyc == 5) chk("wrap_pcd2", w.PCD, 32'h0);
  endtask

  // One clock: sample memory handshakes mid-cycle, then drive the next cycle.
  task automatic cycle();
    logic acc, wacc;
    logic [31:0] a, wa;
    @(negedge clk);
    acc  = f.imem_req && f.imem_ready;
    a    = f.imem_addr;
    wacc = w.imem_req && w.imem_ready;
    wa   = w.imem_addr;
    if (dir) dir_check();
    @(posedge clk);
    #1;
    f.imem_rvalid = 1'b0;
    f.imem_rdata  = $urandom;
    w.imem_rvalid = wacc && !rst;
    w.imem_rdata  = word(wa);
    if (rst) begin
      busy = 1'b0;
    end else begin
      if (acc) begin
        busy  = 1'b1;
        baddr = a;
        cnt   = dir ? 1 : int'($urandom_range(1, 4));
      end
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          f.imem_rvalid = 1'b1;
          f.imem_rdata  = word(baddr);
          busy          = 1'b0;
        end
      end
    end
    if (rnd) begin
      f.StallD     = ($urandom_range(0, 99) < 30);
      f.FlushD     = ($urandom_range(0, 99) < 5);
      f.PCSrcE     = ($urandom_range(0, 99) < 4);
      f.PCTargetE  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                                 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      f.imem_ready = ($urandom_range(0, 99) < 70);
    end
  endtask

  task automatic quiet_inputs();
    f.StallD = 1'b0; f.FlushD = 1'b0; f.PCSrcE = 1'b0; f.PCTargetE = '0;
    f.imem_ready = 1'b1;
  endtask

  // Monitor / scoreboard: program-order model of what decode must see.
  always @(negedge clk) begin
    if (rst_last) begin
      chk("rst_validd", 32'(f.ValidD), 32'h0);
      chk("rst_pcd", f.PCD, 32'h0);
      chk("rst_instrd", f.InstrD, 32'h0);
      chk("rst_pcp4d", f.PCPlus4D, 32'h0);
    end
    if (rst) begin
      chk("req_in_rst", 32'(f.imem_req), 32'h0);
      exp_pc = 32'h0;
      nf     = 32'h0;
      outst  = 1'b0;
      h_hold = 1'b0;
      h_kill = 1'b0;
      idle   = 0;
    end else begin
      if (h_hold) begin
        chk("hold_valid", 32'(f.ValidD), 32'h1);
        chk("hold_instr", f.InstrD, h_instr);
        chk("hold_pcd", f.PCD, h_pcd);
        chk("hold_pcp4", f.PCPlus4D, h_pc4);
      end
      if (h_kill) chk("kill_valid", 32'(f.ValidD), 32'h0);

      if (outst || f.PCSrcE || (f.ValidD && f.StallD))
        chk("req_gate", 32'(f.imem_req), 32'h0);
      if (f.imem_rvalid) outst = 1'b0;
      if (f.imem_req && f.imem_ready) begin
        chk("fetch_addr", f.imem_addr, nf);
        nf    = nf + 32'd4;
        outst = 1'b1;
      end
      if (f.PCSrcE) nf = f.PCTargetE;

      if (f.ValidD) begin
        chk("dec_pcd", f.PCD, exp_pc);
        chk("dec_instr", f.InstrD, word(f.PCD));
        chk("dec_pcp4", f.PCPlus4D, f.PCD + 32'd4);
      end
      if (f.ValidD && !f.StallD && !f.FlushD && !f.PCSrcE) begin
        delivered++;
        idle = 0;
      end else begin
        idle++;
        if (idle > max_idle) max_idle = idle;
      end
      if (f.PCSrcE) exp_pc = f.PCTargetE;
      else if (f.ValidD && (f.FlushD || !f.StallD)) exp_pc = exp_pc + 32'd4;

      h_hold  = f.ValidD && f.StallD && !f.FlushD && !f.PCSrcE;
      h_kill  = f.FlushD || f.PCSrcE;
      h_instr = f.InstrD;
      h_pcd   = f.PCD;
      h_pc4   = f.PCPlus4D;
    end
    rst_last = rst;
  end

  initial begin
    rst = 1'b1;
    quiet_inputs();
    f.imem_rvalid = 1'b0; f.imem_rdata = '0;
    w.StallD = 1'b0; w.FlushD = 1'b0; w.PCSrcE = 1'b0; w.PCTargetE = '0;
    w.imem_ready = 1'b1; w.imem_rvalid = 1'b0; w.imem_rdata = '0;
    repeat (2) cycle();
    rst = 1'b0;

    // Zero-wait memory, no back-pressure: cadence and wrap.
    dir = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc++;
      cycle();
    end
    dir = 1'b0;

    rnd = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        rnd = 1'b0;
        rst = 1'b1;
        quiet_inputs();
        cycle();
        cycle();
        rst = 1'b0;
        rnd = 1'b1;
      end
      cycle();
    end
    rnd = 1'b0;
    quiet_inputs();
    repeat (20) cycle();

    chk("delivered_min", 32'(delivered > 100), 32'h1);
    chk("progress_bound", 32'(max_idle < 200), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with IF/ID register, directly upstream of the control unit in the pipelined core.
- Owns the PC and issues one-outstanding requests to a variable-latency instruction memory. Presents InstrD/PCD/PCPlus4D with ValidD to decode.
- Decode slices InstrD into Op=[6:0], funct3=[14:12], funct7=[31:25].
- Handles decode back-pressure (StallD), decode flush (FlushD) and branch/jump redirect (PCSrcE/PCTargetE).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (current PC)
imem_ready  input  1  memory accepts request this cycle (imem_req && imem_ready = accept)
imem_rvalid  input  1  response valid, exactly one per accepted request, ≥1 cycle after accept
imem_rdata  input  32  instruction word
StallD  input  1  decode cannot take a new instruction; hold IF/ID
FlushD  input  1  invalidate the IF/ID entry
PCSrcE  input  1  redirect taken
PCTargetE  input  32  redirect target (word aligned)
InstrD  output  32  IF/ID instruction
PCD  output  32  PC of InstrD
PCPlus4D  output  32  PCD+4
ValidD  output  1  IF/ID holds a live instruction

Behaviour:
- Reset values:
  - pc=RESET_PC, state=IDLE, ValidD=0, InstrD=PCD=PCPlus4D=0.
  - Skid entry empty; imem_req=0 while rst=1.
- State machine: IDLE (nothing outstanding), WAIT (request outstanding, response wanted), DROP (request outstanding, response stale).
- imem_req = state==IDLE && !skid_valid && (!ValidD || !StallD) && !PCSrcE && !rst. imem_addr = pc.
- On accept:
  - req_pc<=pc, pc<=pc+4 (mod 2^32 wrap), state->WAIT.
  - Same-cycle response to the same request is not allowed.
- In WAIT, on imem_rvalid:
  - If IF/ID is free or consumed this cycle (!ValidD || !StallD): load InstrD=imem_rdata, PCD=req_pc, PCPlus4D=req_pc+4, ValidD=1.
  - Otherwise write to the 1-entry skid buffer.
  - state->IDLE in both cases.
- Skid drain: when skid_valid && !StallD, skid moves into IF/ID next edge and skid_valid clears. A new request may issue the cycle after the skid empties.
- StallD=1: IF/ID outputs hold bit-exact; pc does not advance.
- Latency:
  - Zero-wait memory (ready=1, rvalid one cycle after accept): one instruction every 2 cycles.
  - The first ValidD is at cycle 3 after rst deassert.
- FlushD (no PCSrcE): ValidD<=0 next edge. Skid entry and outstanding request are unaffected. FlushD overrides StallD for the IF/ID entry.
- PCSrcE (priority over FlushD and normal operation):
  - pc<=PCTargetE; ValidD<=0; skid cleared.
  - In WAIT without rvalid: ->DROP.
  - In WAIT with rvalid the same cycle: response discarded, ->IDLE.
  - In IDLE: stay IDLE; no request was issued this cycle.
- DROP: on imem_rvalid, discard the data, ->IDLE. A PCSrcE while in DROP only updates pc.
- rst mid-operation:
  - Returns to reset state next edge regardless of outstanding request.
  - The memory side is also reset by the same rst; a late rvalid after reset is not expected.
- Priority per edge: rst > PCSrcE > FlushD > StallD > normal update.

Test Plan:
- Reset/sequential: rst 2 cycles, RESET_PC=0, zero-wait memory returning addr-tagged words -> ValidD first high cycle 3 with PCD=0; then PCD=4,8,12 every 2 cycles; PCPlus4D=PCD+4.
- Variable latency: rvalid 3 cycles after each accept -> only one outstanding; imem_req low in WAIT; next request the cycle after the response.
- Stall/skid: StallD=1 for 4 cycles while response for PC 8 arrives -> InstrD/PCD=4 held; skid holds PC 8; no new req. StallD drop -> PCD=8 next edge, then request to 12.
- Redirect in WAIT: request to 0x10 outstanding, PCSrcE=1, PCTargetE=0x100 -> state DROP; ValidD=0; response for 0x10 discarded; next imem_addr=0x100; PCD=0x100 delivered.
- Simultaneous redirect + rvalid: PCSrcE and rvalid same cycle -> data dropped; ValidD=0; next edge imem_req with addr=target.
- Flush/stall overlap and wrap: FlushD with StallD=1 -> ValidD=0 next edge. RESET_PC=0xFFFF_FFFC -> second fetch addr 0x0000_0000.
